// File: rtl/addr_burst_split_pkg.sv
// ---------------------------------------------------------------------------
// addr_burst_split_pkg
// Shared constants for the extended-address path: local (per-chip) address
// width, chip index width, number of populated chips, burst length width,
// the burst splitter state encoding and the last valid extended address.
// The address-extension stage uses the same width constants.
// ---------------------------------------------------------------------------
package addr_burst_split_pkg;

    localparam int BIT_ADDR_EX = 19;   // local address width inside one chip
    localparam int BIT_CHIP    = 6;    // chip index width
    localparam int NUM_CHIPS   = 40;   // populated chips (<= 2**BIT_CHIP)
    localparam int BIT_LEN     = 8;    // burst length field (beats minus one)
    localparam int BIT_EXT     = BIT_ADDR_EX + BIT_CHIP;

    // Highest addressable location: last word of the last populated chip.
    localparam logic [BIT_EXT-1:0] LAST_EXT_ADDR =
        {BIT_CHIP'(NUM_CHIPS - 1), {BIT_ADDR_EX{1'b1}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/addr_burst_split_dec.sv
// ---------------------------------------------------------------------------
// chip_onehot_dec
// One-hot decoder from a chip index to per-chip select lines.
// Ports:
//   en     : enable; all outputs are zero when low
//   idx    : chip index
//   onehot : one bit per populated chip; indices >= NUM_CHIPS decode to zero
// ---------------------------------------------------------------------------
module chip_onehot_dec #(
    parameter int BIT_CHIP  = 6,
    parameter int NUM_CHIPS = 40
) (
    input  logic                 en,
    input  logic [BIT_CHIP-1:0]  idx,
    output logic [NUM_CHIPS-1:0] onehot
);

    // Only NUM_CHIPS comparators exist, so out-of-range indices simply match
    // nothing and produce an all-zero select.
    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_sel
        assign onehot[gi] = en & (idx == BIT_CHIP'(gi));
    end

endmodule

// File: rtl/addr_burst_split.sv
// ---------------------------------------------------------------------------
// addr_burst_split
// Splits a burst command (start extended address + length) into single
// beats. The extended address carries the chip index in its upper BIT_CHIP
// bits and the local address in the lower BIT_ADDR_EX bits; incrementing
// across the full width lets a local-address rollover carry into the next
// chip. A burst running past the last populated chip is cut short and
// flagged on err.
// Ports:
//   clk, clr_n             : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      : command handshake
//   in_addr, in_len        : start address, beats minus one
//   out_valid/out_ready    : beat handshake
//   out_chip, out_addr     : chip index and local address of the beat
//   out_cs                 : one-hot of out_chip, zero while out_valid is low
//   out_last               : final beat of the burst
//   err                    : one-cycle pulse for a bad command or truncation
// ---------------------------------------------------------------------------
module addr_burst_split #(
    parameter int BIT_ADDR_EX = addr_burst_split_pkg::BIT_ADDR_EX,
    parameter int BIT_CHIP    = addr_burst_split_pkg::BIT_CHIP,
    parameter int NUM_CHIPS   = addr_burst_split_pkg::NUM_CHIPS,
    parameter int BIT_LEN     = addr_burst_split_pkg::BIT_LEN
) (
    input  logic                          clk,
    input  logic                          clr_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIT_ADDR_EX+BIT_CHIP-1:0] in_addr,
    input  logic [BIT_LEN-1:0]            in_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIT_CHIP-1:0]           out_chip,
    output logic [BIT_ADDR_EX-1:0]        out_addr,
    output logic [NUM_CHIPS-1:0]          out_cs,
    output logic                          out_last,
    output logic                          err
);

    import addr_burst_split_pkg::*;

    localparam int AW = BIT_ADDR_EX + BIT_CHIP;

    // Last word of the last populated chip for this parameterisation.
    localparam logic [AW-1:0] LAST_ADDR =
        {BIT_CHIP'(NUM_CHIPS - 1), {BIT_ADDR_EX{1'b1}}};

    state_e              state_q, state_d;
    logic [AW-1:0]       cur_addr_q, cur_addr_d;
    logic [BIT_LEN-1:0]  remaining_q, remaining_d;
    logic                out_last_q, out_last_d;
    logic                err_q, err_d;

    logic [BIT_CHIP-1:0] in_chip;
    logic                cmd_bad;
    logic                cur_is_end;

    assign in_chip = in_addr[AW-1 -: BIT_CHIP];

    // One extra bit so that NUM_CHIPS == 2**BIT_CHIP does not wrap to zero.
    assign cmd_bad = {1'b0, in_chip} >= (BIT_CHIP + 1)'(NUM_CHIPS);

    assign cur_is_end = (cur_addr_q == LAST_ADDR);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (cmd_bad) begin
                        // Rejected: flag it and stay ready for the next one.
                        err_d = 1'b1;
                    end else begin
                        cur_addr_d  = in_addr;
                        remaining_d = in_len;
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    if (remaining_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (cur_is_end) begin
                        // Beats still owed but no chip left to address.
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cur_addr_d  = cur_addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // out_last is registered alongside the address it describes.
        out_last_d = (state_d == ST_RUN) &&
                     ((remaining_d == '0) || (cur_addr_d == LAST_ADDR));
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_RUN);
    end

    assign out_chip = cur_addr_q[AW-1 -: BIT_CHIP];
    assign out_addr = cur_addr_q[BIT_ADDR_EX-1:0];
    assign out_last = out_last_q;
    assign err      = err_q;

    chip_onehot_dec #(
        .BIT_CHIP  (BIT_CHIP),
        .NUM_CHIPS (NUM_CHIPS)
    ) u_cs_dec (
        .en     (out_valid),
        .idx    (out_chip),
        .onehot (out_cs)
    );

endmodule

// File: tb/tb_addr_burst_split.sv
module tb_addr_burst_split;
    import addr_burst_split_pkg::*;

    localparam int AW = BIT_ADDR_EX + BIT_CHIP;

    typedef struct packed {
        logic [BIT_CHIP-1:0]    chip;
        logic [BIT_ADDR_EX-1:0] addr;
        logic                   last;
    } beat_t;

    typedef struct {
        logic [AW-1:0]      addr;
        logic [BIT_LEN-1:0] len;
        bit                 rand_ready;
        int                 exp_beats;
        int                 exp_err;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   clr_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [AW-1:0]          in_addr = '0;
    logic [BIT_LEN-1:0]     in_len = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [BIT_CHIP-1:0]    out_chip;
    logic [BIT_ADDR_EX-1:0] out_addr;
    logic [NUM_CHIPS-1:0]   out_cs;
    logic                   out_last;
    logic                   err;

    int    checks = 0;
    int    errors = 0;
    int    beat_cnt = 0;
    int    err_cnt = 0;
    bit    rand_mode = 1'b0;
    bit    manual_ready = 1'b1;
    beat_t exp_q[$];

    addr_burst_split dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chip  (out_chip),
        .out_addr  (out_addr),
        .out_cs    (out_cs),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: beats a command should produce, in order.
    task automatic push_model(input logic [AW-1:0] a0, input logic [BIT_LEN-1:0] len);
        logic [AW-1:0] a;
        int n;
        a = a0;
        n = int'(len);
        if (int'(a0[AW-1 -: BIT_CHIP]) >= NUM_CHIPS) return;
        for (int i = 0; i <= n; i++) begin
            beat_t b;
            b.chip = a[AW-1 -: BIT_CHIP];
            b.addr = a[BIT_ADDR_EX-1:0];
            b.last = (i == n) || (a == LAST_EXT_ADDR);
            exp_q.push_back(b);
            if (b.last) break;
            a = a + 1'b1;
        end
    endtask

    // out_ready driver: random backpressure or a value set by the sequences.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : manual_ready;
        end
    end

    // Monitor / scoreboard.
    beat_t prev_beat;
    bit    prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!clr_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_beat", 64'({out_chip, out_addr, out_last}), 64'(prev_beat));
            end
            if (out_valid && out_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'({out_chip, out_addr}), 64'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    logic [NUM_CHIPS-1:0] ecs;
                    e = exp_q.pop_front();
                    ecs = '0;
                    ecs[e.chip] = 1'b1;
                    chk("beat_chip", 64'(out_chip), 64'(e.chip));
                    chk("beat_addr", 64'(out_addr), 64'(e.addr));
                    chk("beat_last", 64'(out_last), 64'(e.last));
                    chk("beat_cs", 64'(out_cs), 64'(ecs));
                end
            end else if (!out_valid) begin
                chk("cs_idle_zero", 64'(out_cs), 64'd0);
            end
            if (err) err_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_beat  = '{chip: out_chip, addr: out_addr, last: out_last};
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [BIT_LEN-1:0] len);
        in_addr  = a;
        in_len   = len;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int b0, e0;

        vecs[0] = '{{6'd3,  19'h00010}, 8'd2,   1'b0, 3,   0};
        vecs[1] = '{{6'd5,  19'h7FFFF}, 8'd1,   1'b0, 2,   0};
        vecs[2] = '{{6'd40, 19'h00000}, 8'd4,   1'b0, 0,   1};
        vecs[3] = '{{6'd39, 19'h7FFFF}, 8'd3,   1'b0, 1,   1};
        vecs[4] = '{{6'd0,  19'h00000}, 8'd0,   1'b0, 1,   0};
        vecs[5] = '{{6'd10, 19'h7FFFE}, 8'd5,   1'b1, 6,   0};
        vecs[6] = '{{6'd63, 19'h00001}, 8'd0,   1'b0, 0,   1};
        vecs[7] = '{{6'd39, 19'h7FFFD}, 8'd255, 1'b1, 3,   1};
        vecs[8] = '{{6'd20, 19'h00100}, 8'd255, 1'b1, 256, 0};
        vecs[9] = '{{6'd39, 19'h7FFF0}, 8'd15,  1'b1, 16,  0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_chip", 64'(out_chip), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_cs", 64'(out_cs), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven commands.
        for (int i = 0; i < 10; i++) begin
            rand_mode = vecs[i].rand_ready;
            b0 = beat_cnt;
            e0 = err_cnt;
            push_model(vecs[i].addr, vecs[i].len);
            send_cmd(vecs[i].addr, vecs[i].len);
            wait_idle();
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_beats", i), 64'(beat_cnt - b0), 64'(vecs[i].exp_beats));
            chk($sformatf("vec%0d_err", i), 64'(err_cnt - e0), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_q_empty", i), 64'(exp_q.size()), 64'd0);
        end
        rand_mode = 1'b0;
        manual_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Latency and in_ready return timing for a 3-beat burst.
        push_model({6'd3, 19'h00010}, 8'd2);
        send_cmd({6'd3, 19'h00010}, 8'd2);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_addr", 64'(out_addr), 64'h10);
        chk("lat_in_ready_busy", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("lat_beat3_last", 64'(out_last), 64'd1);
        @(posedge clk);
        #1;
        chk("lat_in_ready_back", 64'(in_ready), 64'd1);
        chk("lat_valid_drop", 64'(out_valid), 64'd0);

        // Bad chip index: err exactly one cycle, no beats, stays ready.
        e0 = err_cnt;
        send_cmd({6'd40, 19'h0}, 8'd4);
        chk("bad_err_pulse", 64'(err), 64'd1);
        chk("bad_no_valid", 64'(out_valid), 64'd0);
        chk("bad_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bad_err_drop", 64'(err), 64'd0);
        chk("bad_no_valid2", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("bad_err_count", 64'(err_cnt - e0), 64'd1);

        // Backpressure on beat 2 for 3 cycles.
        b0 = beat_cnt;
        push_model({6'd3, 19'h00010}, 8'd2);
        send_cmd({6'd3, 19'h00010}, 8'd2);
        @(posedge clk);
        #1;
        manual_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_held_addr", 64'(out_addr), 64'h11);
        manual_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("stall_beats", 64'(beat_cnt - b0), 64'd3);
        chk("stall_q_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a 10-beat burst.
        e0 = err_cnt;
        push_model({6'd7, 19'h0}, 8'd9);
        send_cmd({6'd7, 19'h0}, 8'd9);
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_chip", 64'(out_chip), 64'd0);
        chk("abort_addr", 64'(out_addr), 64'd0);
        chk("abort_cs", 64'(out_cs), 64'd0);
        chk("abort_last", 64'(out_last), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_in_ready", 64'(in_ready), 64'd1);
            chk("abort_idle_valid", 64'(out_valid), 64'd0);
        end
        chk("abort_no_err", 64'(err_cnt - e0), 64'd0);

        // Fresh command after the abort still works.
        push_model({6'd1, 19'h00005}, 8'd1);
        send_cmd({6'd1, 19'h00005}, 8'd1);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("post_abort_q_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
